// File: rtl/ahb_sub_dmem.sv
// AHB-Lite data-memory subordinate: word RAM with byte/half/word lanes, load extension and wait states.
// Define DMEM_ERR_EN for the error check and ERROR response; without it addresses wrap and are force-aligned.
module ahb_sub_dmem #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_2000,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  unsign_i,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int OFF_W = IDX_W + 2;

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT, S_ERR1, S_ERR2} state_e;

    state_e                 state_q;
    logic [3:0]             wcnt_q;
    logic [OFF_W-1:0]       off_q;
    logic                   write_q;
    logic [1:0]             size_q;
    logic                   unsign_q;
    logic                   hreadyout_q;
    logic                   hresp_q;

    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0]  offset;
    logic                   accept;
    logic [1:0]             size_d;
    logic [OFF_W-1:0]       off_d;
    logic                   err_d;

    assign offset = HADDR - BASE_ADDR;
    assign accept = HSEL & HREADY & HTRANS[1];
    assign size_d = (HSIZE == 3'd0) ? 2'd0 : (HSIZE == 3'd1) ? 2'd1 : 2'd2;

`ifdef DMEM_ERR_EN
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);

    assign err_d = (HSIZE > 3'd2)
                 | ((HSIZE == 3'd1) & HADDR[0])
                 | ((HSIZE == 3'd2) & (|HADDR[1:0]))
                 | (offset >= MEM_BYTES);
    assign off_d = offset[OFF_W-1:0];
    assign HRESP = hresp_q;
`else
    // Out-of-range offsets wrap by truncation; low bits are cleared to the transfer size.
    assign err_d = 1'b0;
    assign off_d = {offset[OFF_W-1:2],
                    offset[1] & (size_d == 2'd0 || size_d == 2'd1) ,
                    offset[0] & (size_d == 2'd0)};
    assign HRESP = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], offset[ADDR_WIDTH-1:OFF_W], hresp_q};

    assign HREADYOUT = hreadyout_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            wcnt_q      <= 4'd0;
            off_q       <= '0;
            write_q     <= 1'b0;
            size_q      <= 2'd0;
            unsign_q    <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DATA, S_ERR2: begin
                    if (accept) begin
                        off_q    <= off_d;
                        write_q  <= HWRITE;
                        size_q   <= size_d;
                        unsign_q <= unsign_i;
                        if (err_d) begin
                            state_q     <= S_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state_q     <= S_WAIT;
                            wcnt_q      <= 4'(WAIT_STATES);
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 1'b0;
                        end else begin
                            state_q     <= S_DATA;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= 1'b0;
                        end
                    end else begin
                        state_q     <= S_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 1'b0;
                    end
                end
                S_WAIT: begin
                    wcnt_q <= wcnt_q - 4'd1;
                    if (wcnt_q <= 4'd1) begin
                        state_q     <= S_DATA;
                        hreadyout_q <= 1'b1;
                    end
                end
                S_ERR1: begin
                    state_q     <= S_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                end
            endcase
        end
    end

    logic [3:0]       be;
    logic [IDX_W-1:0] widx;

    assign widx = off_q[OFF_W-1:2];
    assign be   = (size_q == 2'd0) ? (4'b0001 << off_q[1:0]) :
                  (size_q == 2'd1) ? (off_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    // NOTE: the RAM array has no reset; only control state is cleared by HRESETn.
    always_ff @(posedge HCLK) begin
        if (state_q == S_DATA && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    logic [DATA_WIDTH-1:0] rword;
    logic [7:0]            rbyte;
    logic [15:0]           rhalf;
    logic                  sext;
    logic [DATA_WIDTH-1:0] rdata_d;

    assign rword = mem[widx];
    assign rbyte = rword[{off_q[1:0], 3'b000} +: 8];
    assign rhalf = off_q[1] ? rword[31:16] : rword[15:0];
    assign sext  = ~unsign_q;

    always_comb begin
        // NOTE: default first so every path assigns rdata_d and no latch is inferred.
        rdata_d = '0;
        if (state_q == S_DATA && !write_q) begin
            unique case (size_q)
                2'd0:    rdata_d = {{24{sext & rbyte[7]}}, rbyte};
                2'd1:    rdata_d = {{16{sext & rhalf[15]}}, rhalf};
                default: rdata_d = rword;
            endcase
        end
    end

    assign HRDATA = rdata_d;

endmodule

// File: tb/tb_ahb_sub_dmem.sv
// Bench for ahb_sub_dmem: two instances (0 and 2 wait states) on a shared bus, byte-level reference model.
module tb_ahb_sub_dmem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        uns;
    logic        tgt;
    logic        dtgt = 1'b0;

    logic        ro0, ro1, rsp0, rsp1;
    logic [31:0] rd0, rd1;
    logic        hready, hresp_m;
    logic [31:0] hrdata_m;

    assign hready   = dtgt ? ro1  : ro0;
    assign hresp_m  = dtgt ? rsp1 : rsp0;
    assign hrdata_m = dtgt ? rd1  : rd0;

    always @(posedge clk) if (hready) dtgt <= tgt;

    ahb_sub_dmem #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel & ~tgt), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HTRANS(htrans), .HMASTLOCK(1'b0),
        .HREADY(hready), .HWDATA(hwdata), .unsign_i(uns),
        .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rsp0)
    );

    ahb_sub_dmem #(.WAIT_STATES(2)) u_dut2 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel & tgt), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HTRANS(htrans), .HMASTLOCK(1'b0),
        .HREADY(hready), .HWDATA(hwdata), .unsign_i(uns),
        .HRDATA(rd1), .HREADYOUT(ro1), .HRESP(rsp1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference model: one byte array per instance, addressed by byte offset from the base.
    logic [7:0] mdl [2][4096];

    function automatic logic m_err(input logic [31:0] a, input logic [2:0] s);
`ifdef DMEM_ERR_EN
        logic [31:0] off;
        off = a - 32'h2000;
        return (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'd0) || (off >= 32'd4096);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_nb(input logic [2:0] s);
        return (s == 3'd0) ? 1 : (s == 3'd1) ? 2 : 4;
    endfunction

    function automatic int m_off(input logic [31:0] a, input logic [2:0] s);
        int off;
        off = int'((a - 32'h2000) % 32'd4096);
        off = off - (off % m_nb(s));
        return off;
    endfunction

    function automatic logic [31:0] m_read(input logic t, input logic [31:0] a, input logic [2:0] s, input logic u);
        logic [31:0] v;
        int off, nb;
        off = m_off(a, s);
        nb  = m_nb(s);
        v   = 32'h0;
        for (int k = 0; k < nb; k++) v = v | (32'(mdl[t][off + k]) << (8 * k));
        if (!u && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
        return v;
    endfunction

    task automatic m_write(input logic t, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        int off;
        off = m_off(a, s);
        for (int k = 0; k < m_nb(s); k++) mdl[t][off + k] = d[8*((off + k) % 4) +: 8];
    endtask

    logic        q_w [64];
    logic [31:0] q_a [64];
    logic [2:0]  q_s [64];
    logic        q_u [64];
    logic [31:0] q_d [64];
    int          n;
    logic [31:0] last_rd;

    task automatic add(input logic w, input logic [31:0] a, input logic [2:0] s, input logic u, input logic [31:0] d);
        q_w[n] = w; q_a[n] = a; q_s[n] = s; q_u[n] = u; q_d[n] = d;
        n++;
    endtask

    // Issues the queued transfers back-to-back; called just after a rising edge with the bus idle.
    task automatic run_seq();
        int          waits;
        logic        e;
        logic [31:0] er;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                hsel = 1'b1; htrans = 2'b10; haddr = q_a[i]; hwrite = q_w[i]; hsize = q_s[i]; uns = q_u[i];
            end else begin
                hsel = 1'b0; htrans = 2'b00;
            end
            if (i == 0) begin
                @(posedge clk); #1;
            end else begin
                hwdata = q_d[i-1];
                e      = m_err(q_a[i-1], q_s[i-1]);
                er     = (q_w[i-1] || e) ? 32'h0 : m_read(tgt, q_a[i-1], q_s[i-1], q_u[i-1]);
                waits  = 0;
                forever begin
                    @(negedge clk);
                    if (hready === 1'b1 || waits > 20) break;
                    waits++;
                    check("wait_resp", 32'(hresp_m), 32'(e));
                    check("wait_rdata", hrdata_m, 32'h0);
                    @(posedge clk); #1;
                end
                check("waits", waits, e ? 1 : (tgt ? 2 : 0));
                check("resp", 32'(hresp_m), 32'(e));
                check("rdata", hrdata_m, er);
                last_rd = hrdata_m;
                if (q_w[i-1] && !e) m_write(tgt, q_a[i-1], q_s[i-1], q_d[i-1]);
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] old, keep, a;
        logic [2:0]  s;

        rst_n = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0;
        hsize = 3'd0; hwdata = 32'h0; uns = 1'b0; tgt = 1'b0; n = 0; last_rd = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready0", 32'(ro0), 32'h1);
        check("rst_resp0", 32'(rsp0), 32'h0);
        check("rst_rdata0", rd0, 32'h0);
        check("rst_ready2", 32'(ro1), 32'h1);
        check("rst_resp2", 32'(rsp1), 32'h0);
        check("rst_rdata2", rd1, 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Preload every word of both RAMs so all later reads are defined.
        for (int t = 0; t < 2; t++) begin
            tgt = 1'(t);
            for (int b = 0; b < 1024; b += 32) begin
                n = 0;
                for (int k = 0; k < 32; k++) add(1'b1, 32'h2000 + 32'(4 * (b + k)), 3'd2, 1'b0, $urandom);
                run_seq();
            end
        end

        tgt = 1'b0;
        n = 0;
        add(1'b1, 32'h2000, 3'd2, 1'b0, 32'hDEAD_BEEF);
        add(1'b0, 32'h2000, 3'd2, 1'b0, 32'h0);
        run_seq();
        check("word_rd", last_rd, 32'hDEAD_BEEF);

        old = m_read(1'b0, 32'h2004, 3'd2, 1'b1);
        n = 0;
        add(1'b1, 32'h2005, 3'd0, 1'b0, 32'h5A5A_805A);
        add(1'b0, 32'h2005, 3'd0, 1'b0, 32'h0);
        run_seq();
        check("byte_signed", last_rd, 32'hFFFF_FF80);
        n = 0;
        add(1'b0, 32'h2005, 3'd0, 1'b1, 32'h0);
        run_seq();
        check("byte_unsigned", last_rd, 32'h0000_0080);
        n = 0;
        add(1'b0, 32'h2004, 3'd2, 1'b0, 32'h0);
        run_seq();
        check("byte_lane_only", last_rd, (old & 32'hFFFF_00FF) | 32'h0000_8000);

        n = 0;
        add(1'b1, 32'h200A, 3'd1, 1'b0, 32'hBEEF_1234);
        add(1'b0, 32'h200A, 3'd1, 1'b0, 32'h0);
        run_seq();
        check("half_b2b", last_rd, 32'hFFFF_BEEF);

        tgt = 1'b1;
        n = 0;
        add(1'b1, 32'h2010, 3'd2, 1'b0, 32'hCAFE_F00D);
        add(1'b0, 32'h2010, 3'd2, 1'b0, 32'h0);
        run_seq();
        check("ws2_rd", last_rd, 32'hCAFE_F00D);
        @(negedge clk);
        check("idle_ready", 32'(hready), 32'h1);
        check("idle_resp", 32'(hresp_m), 32'h0);
        @(posedge clk); #1;

`ifdef DMEM_ERR_EN
        tgt = 1'b0;
        old = m_read(1'b0, 32'h2000, 3'd2, 1'b1);
        n = 0;
        add(1'b0, 32'h2002, 3'd2, 1'b0, 32'h0);
        add(1'b1, 32'h2002, 3'd2, 1'b0, 32'h1234_5678);
        add(1'b0, 32'h3000, 3'd0, 1'b0, 32'h0);
        add(1'b1, 32'h3000, 3'd2, 1'b0, 32'h8765_4321);
        add(1'b0, 32'h2000, 3'd2, 1'b0, 32'h0);
        run_seq();
        check("err_no_write", last_rd, old);
`else
        tgt = 1'b0;
        n = 0;
        add(1'b1, 32'h3004, 3'd2, 1'b0, 32'hA5A5_0F0F);
        add(1'b0, 32'h2004, 3'd2, 1'b0, 32'h0);
        run_seq();
        check("wrap_rd", last_rd, 32'hA5A5_0F0F);
        n = 0;
        add(1'b1, 32'h2013, 3'd2, 1'b0, 32'h0102_0304);
        add(1'b0, 32'h2010, 3'd2, 1'b0, 32'h0);
        run_seq();
        check("align_rd", last_rd, 32'h0102_0304);
`endif

        // Reset in the middle of a waited write must drop the write.
        tgt  = 1'b1;
        a    = 32'h2020;
        keep = m_read(1'b1, a, 3'd2, 1'b1);
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = ~keep;
        @(negedge clk);
        check("rst_in_wait", 32'(hready), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(ro1), 32'h1);
        check("rst_mid_resp", 32'(rsp1), 32'h0);
        check("rst_mid_rdata", rd1, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n = 0;
        add(1'b0, a, 3'd2, 1'b0, 32'h0);
        run_seq();
        check("rst_word_kept", last_rd, keep);

        for (int b = 0; b < 20; b++) begin
            tgt = 1'($urandom_range(0, 1));
            n = 0;
            for (int k = 0; k < 10; k++) begin
                s = 3'($urandom_range(0, 2));
`ifdef DMEM_ERR_EN
                case ($urandom_range(0, 7))
                    0:       a = 32'h3000 + $urandom_range(0, 255);
                    1:       a = 32'h1FF0 + $urandom_range(0, 15);
                    default: a = 32'h2000 + $urandom_range(0, 4095);
                endcase
                if ($urandom_range(0, 15) == 0) s = 3'd3;
`else
                a = 32'h2000 + $urandom_range(0, 16383);
`endif
                add(1'($urandom_range(0, 1)), a, s, 1'($urandom_range(0, 1)), $urandom);
            end
            run_seq();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_sub_dmem.md
Name: ahb_sub_dmem

Overview:
- AHB-Lite subordinate that terminates transfers from the memory-stage AHB manager.
- Backs a word-organised data RAM and applies byte/half/word lane selection on writes.
- Applies sign or zero extension on reads, driven by the manager's unsign side-band.
- Supports programmable wait states and a two-cycle ERROR response. Sits on the data-side AHB bus after the address decoder's HSEL.

Parameters:
- ADDR_WIDTH, 32, HADDR width.
- DATA_WIDTH, 32, HWDATA/HRDATA width (only 32 supported).
- MEM_DEPTH, 1024, RAM depth in 32-bit words (power of two).
- BASE_ADDR, 32'h0000_2000, byte address of word 0.
- WAIT_STATES, 0, extra data-phase cycles inserted per OKAY transfer (0..15).

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  subordinate select from decoder.
- HADDR  in  ADDR_WIDTH  byte address.
- HWRITE  in  1  1=write.
- HSIZE  in  3  0=byte, 1=half, 2=word.
- HBURST  in  3  ignored (each beat handled as a single).
- HPROT  in  4  ignored.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HMASTLOCK  in  1  ignored.
- HREADY  in  1  bus-level ready (muxed HREADYOUT).
- HWDATA  in  DATA_WIDTH  write data (data phase).
- unsign_i  in  1  1=zero-extend load, 0=sign-extend; sampled in address phase.
- HRDATA  out  DATA_WIDTH  extended read data.
- HREADYOUT  out  1  data phase completes when 1.
- HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (async, HRESETn=0): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, all latched address-phase fields cleared, pending write discarded. RAM contents are not reset. Deassertion takes effect at the next HCLK edge.
- Accept: HSEL & HREADY & HTRANS[1] at a rising edge. Latch HADDR, HWRITE, HSIZE, unsign_i. Compute err = (HSIZE>2) | (misaligned: half with HADDR[0]=1, word with HADDR[1:0]!=0) | (HADDR-BASE_ADDR >= MEM_DEPTH*4, unsigned).
- IDLE/BUSY or HSEL=0 with HREADY=1: next data phase is zero-wait OKAY, no RAM access.
- FSM states: IDLE, DATA, WAIT, ERR1, ERR2.
  - IDLE: accept&!err -> WAIT if WAIT_STATES>0 (counter=WAIT_STATES) else DATA. Accept&err -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=0, counter decrements; at 1 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0; transfer completes this cycle. Next state follows the same accept rules as IDLE (back-to-back pipelining), else IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Next state follows the accept rules; the manager may instead drive IDLE.
- Write: commits at the rising edge ending the DATA cycle. Lane select from latched HADDR[1:0]/HSIZE: byte writes lane HADDR[1:0]; half writes lanes {HADDR[1],0} and +1; word writes all lanes. Data comes from the matching HWDATA lanes. An errored transfer never writes.
- Read: combinational from RAM at the latched address during DATA. Byte/half extracted from the lane and extended per the latched unsign. HRDATA=0 in every non-DATA-read cycle.
- Back-to-back write A then read A: the read data phase returns the new value.
- Index = (HADDR-BASE_ADDR)[log2(MEM_DEPTH)+1:2].

Optional Feature:
- DMEM_ERR_EN defined: error detection and the ERR1/ERR2 response as above.
- Undefined: err is forced 0 and HRESP is tied 0. Out-of-range addresses wrap modulo MEM_DEPTH*4. Misaligned low address bits are forced to the size alignment (half clears bit0, word clears [1:0]).

Test Plan:
- Word write 0x2000 <- 0xDEADBEEF, then word read 0x2000 (WAIT_STATES=0): HRDATA=0xDEADBEEF in the data phase, HREADYOUT=1 throughout, HRESP=0.
- Byte write 0x80 to 0x2005, then byte read 0x2005: unsign_i=0 gives 0xFFFFFF80; unsign_i=1 gives 0x00000080. Word at 0x2004 has only bits[15:8] changed.
- Half write 0xBEEF to 0x200A with back-to-back read of the same half (signed): read data phase returns 0xFFFFBEEF.
- WAIT_STATES=2, word read: HREADYOUT low exactly 2 cycles then high for one cycle with data. An IDLE following the transfer gives OKAY, zero wait.
- DMEM_ERR_EN: word read at 0x2002, or any access at 0x3000: cycle 1 HREADYOUT=0/HRESP=1, cycle 2 HREADYOUT=1/HRESP=1; a write at 0x2002 leaves RAM unchanged.
- Assert HRESETn=0 mid-WAIT of a write: outputs immediately HREADYOUT=1/HRESP=0/HRDATA=0; the target word is unchanged.
